// File: rtl/jtkiwi_shram_arb_pkg.sv
// Shared definitions for the shared-RAM arbiter: FSM state encoding.
package jtkiwi_shram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM, registered read (read-before-write), no reset on contents.
module jtframe_ram #(
    parameter int dw = 8,
    parameter int aw = 10
) (
    input  logic          clk,
    input  logic          cen,
    input  logic [dw-1:0] data,
    input  logic [aw-1:0] addr,
    input  logic          we,
    output logic [dw-1:0] q
);

    logic [dw-1:0] mem [0:(1<<aw)-1];

    always_ff @(posedge clk) begin
        if (cen) begin
            if (we) mem[addr] <= data;
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/jtkiwi_rr_pick.sv
// Round-robin picker: first pending port strictly after `last`, wrapping at N.
module jtkiwi_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         pend,
    input  logic [$clog2(N)-1:0] last,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int          GW = $clog2(N);
    localparam int unsigned NU = N;

    // Walking offsets 1..N from `last` is the rotate / priority-encode / unrotate in one pass.
    always_comb begin
        int unsigned   j;
        logic [GW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= NU; k++) begin
            j = 32'(last) + k;
            if (j >= NU) j = j - NU;
            cand = GW'(j);
            if (!valid && pend[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/jtkiwi_shram_arb.sv
// N-port round-robin arbiter in front of one shared single-port RAM, with port-0 lock.
module jtkiwi_shram_arb
    import jtkiwi_shram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lock,
    input  logic [N-1:0]         cs,
    input  logic [N-1:0]         rnw,
    input  logic [N*AW-1:0]      addr,
    input  logic [N*DW-1:0]      din,
    output logic [N*DW-1:0]      dout,
    output logic [N-1:0]         ok,
    output logic [$clog2(N)-1:0] gnt,
    output logic                 busy
);

    localparam int GW = $clog2(N);

    state_e          state_q, state_d;
    logic [N-1:0]    served_q, served_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            rnw_q, rnw_d;
    logic [N*DW-1:0] dout_q, dout_d;

    logic [N-1:0]    elig_mask, pend;
    logic            pick_valid;
    logic [GW-1:0]   pick_idx;
    logic [DW-1:0]   ram_q;
    logic            ram_we;

    always_comb begin
        elig_mask = '1;
        if (lock) begin
            elig_mask    = '0;
            elig_mask[0] = 1'b1;
        end
    end

    assign pend = cs & ~served_q & elig_mask;

    jtkiwi_rr_pick #(.N(N)) u_pick (
        .pend  (pend),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    jtframe_ram #(.dw(DW), .aw(AW)) u_ram (
        .clk  (clk),
        .cen  (1'b1),
        .data (din_q),
        .addr (addr_q),
        .we   (ram_we),
        .q    (ram_q)
    );

    assign ram_we = (state_q == ST_ACC) && !rnw_q && !rst;
    assign gnt    = gnt_q;
    assign busy   = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rnw_d    = rnw_q;
        dout_d   = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ACC;
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    addr_d  = addr[int'(pick_idx)*AW +: AW];
                    din_d   = din[int'(pick_idx)*DW +: DW];
                    rnw_d   = rnw[pick_idx];
                end
            end
            ST_ACC:  state_d = ST_ACK;
            ST_ACK: begin
                state_d         = ST_IDLE;
                served_d[gnt_q] = 1'b1;
                if (rnw_q) dout_d[int'(gnt_q)*DW +: DW] = ram_q;
            end
            default: state_d = ST_IDLE;
        endcase
        // A dropped request re-arms its port, even in the cycle it is acknowledged.
        served_d = served_d & cs;
    end

    always_comb begin
        ok   = '0;
        dout = dout_q;
        if (state_q == ST_ACK && !rst) begin
            ok[gnt_q] = 1'b1;
            if (rnw_q) dout[int'(gnt_q)*DW +: DW] = ram_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            served_q <= '0;
            last_q   <= GW'(N-1);
            gnt_q    <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            rnw_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rnw_q    <= rnw_d;
            dout_q   <= dout_d;
        end
    end

endmodule
